or_32_reg: RTL and testbench

- 32-bit bitwise OR unit for the recitation ALU datapath.
- Provides a combinational result, `data_result = a | b`, for direct ALU use.
- Also provides a one-cycle registered copy with a valid strobe, so it can sit in a clocked pipeline stage.
- Single clock domain; no internal state beyond the output register stage.

---
 rtl/or_32_reg_if.sv | 74 +++++++
 rtl/or_32_reg.sv | 66 ++++++
 tb/tb_or_32_reg.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/or_32_reg_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : or_32_reg_if                                                  |
// | Purpose  : Operand/result bundle for the or_32_reg bitwise-OR unit.      |
// | Signals  : a, b        - operands (WIDTH bits)                           |
// |            in_valid    - a/b carry a valid operation this cycle          |
// |            data_result - combinational a | b                             |
// |            result_q    - registered a | b of the last accepted op        |
// |            out_valid   - one-cycle strobe: result_q is new this cycle    |
// |            zero_q      - registered NOR-reduce of a | b (flags build)    |
// |            ones_q      - registered AND-reduce of a | b (flags build)    |
// | Macro    : OR_32_REG_FLAGS_EN adds zero_q / ones_q.                      |
// | Modports : master (operand producer), slave (the OR unit).               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface or_32_reg_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] result_q;
  logic             out_valid;
`ifdef OR_32_REG_FLAGS_EN
  logic             zero_q;
  logic             ones_q;
`endif

`ifdef OR_32_REG_FLAGS_EN
  modport master (
    output a,
    output b,
    output in_valid,
    input  data_result,
    input  result_q,
    input  out_valid,
    input  zero_q,
    input  ones_q
  );

  modport slave (
    input  a,
    input  b,
    input  in_valid,
    output data_result,
    output result_q,
    output out_valid,
    output zero_q,
    output ones_q
  );
`else
  modport master (
    output a,
    output b,
    output in_valid,
    input  data_result,
    input  result_q,
    input  out_valid
  );

  modport slave (
    input  a,
    input  b,
    input  in_valid,
    output data_result,
    output result_q,
    output out_valid
  );
`endif

endinterface
`default_nettype wire

// File: rtl/or_32_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : or_32_reg                                                     |
// | Purpose  : WIDTH-bit bitwise OR with a combinational result and a        |
// |            one-cycle registered copy plus valid strobe for pipelines.    |
// | Ports    : clock  - system clock, rising edge                            |
// |            resetn - synchronous reset, active low                        |
// |            bus    - or_32_reg_if.slave (a, b, in_valid, data_result,     |
// |                     result_q, out_valid [, zero_q, ones_q])              |
// | Macro    : OR_32_REG_FLAGS_EN - adds registered zero_q / ones_q flags.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module or_32_reg #(
  parameter int WIDTH = 32
) (
  input  wire logic    clock,
  input  wire logic    resetn,
  or_32_reg_if.slave   bus
);

  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] r_result_q;
  logic             r_out_valid;

  // Zero-latency path; no clock or reset involvement so X/Z follow plain OR.
  assign w_or            = bus.a | bus.b;
  assign bus.data_result = w_or;

  // Result register only loads on accepted ops; out_valid is a pulse, so it
  // clears on any edge without in_valid. Reset dominates in_valid.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_result_q  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result_q <= w_or;
      end
    end
  end

  assign bus.result_q  = r_result_q;
  assign bus.out_valid = r_out_valid;

`ifdef OR_32_REG_FLAGS_EN
  logic r_zero_q;
  logic r_ones_q;

  // Flags track result_q exactly; reset values describe a zero result.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_zero_q <= 1'b1;
      r_ones_q <= 1'b0;
    end else if (bus.in_valid) begin
      r_zero_q <= ~(|w_or);
      r_ones_q <= &w_or;
    end
  end

  assign bus.zero_q = r_zero_q;
  assign bus.ones_q = r_ones_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_or_32_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_or_32_reg                                                  |
// | Purpose  : Self-checking bench for or_32_reg: directed literal cases     |
// |            plus randomized traffic against a queue-based model.          |
// | Macro    : OR_32_REG_FLAGS_EN - also checks zero_q / ones_q.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_or_32_reg;

  localparam int WIDTH = 32;

  logic clock;
  logic resetn;
  int   n_total;
  int   n_pass;
  bit   cmp_en;

  or_32_reg_if #(.WIDTH(WIDTH)) bus ();

  or_32_reg #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: history of accepted results since the last reset, and
  // whether the most recent edge accepted an op.
  logic [WIDTH-1:0] hist[$];
  bit               last_edge_accepted;

  function automatic logic [WIDTH-1:0] model_q();
    return (hist.size() == 0) ? '0 : hist[hist.size()-1];
  endfunction

  function automatic logic [WIDTH-1:0] ref_or(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = (x[i] === 1'b1 || y[i] === 1'b1);
    return r;
  endfunction

  always @(posedge clock) begin
    if (resetn === 1'b0) begin
      hist.delete();
      last_edge_accepted = 1'b0;
    end else if (bus.in_valid === 1'b1) begin
      hist.push_back(ref_or(bus.a, bus.b));
      last_edge_accepted = 1'b1;
    end else begin
      last_edge_accepted = 1'b0;
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en) begin
      logic [WIDTH-1:0] q;
      q = model_q();
      check("cyc_data_result", bus.data_result, ref_or(bus.a, bus.b));
      check("cyc_result_q", bus.result_q, q);
      check("cyc_out_valid", {{(WIDTH-1){1'b0}}, bus.out_valid},
            {{(WIDTH-1){1'b0}}, last_edge_accepted});
`ifdef OR_32_REG_FLAGS_EN
      check("cyc_zero_q", {{(WIDTH-1){1'b0}}, bus.zero_q},
            {{(WIDTH-1){1'b0}}, (q == '0)});
      check("cyc_ones_q", {{(WIDTH-1){1'b0}}, bus.ones_q},
            {{(WIDTH-1){1'b0}}, (q == '1)});
`endif
    end
  end

  // Drive inputs, then advance through one rising edge; returns #1 after it.
  task automatic apply(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic v, input logic rn);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = v;
    resetn       = rn;
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string name, input logic [WIDTH-1:0] exp_dr,
                     input logic [WIDTH-1:0] exp_q, input logic exp_v);
    check({name, "_data_result"}, bus.data_result, exp_dr);
    check({name, "_result_q"}, bus.result_q, exp_q);
    check({name, "_out_valid"}, {{(WIDTH-1){1'b0}}, bus.out_valid},
          {{(WIDTH-1){1'b0}}, exp_v});
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    cmp_en  = 1'b0;

    // Reset held two cycles with a valid all-ones op presented.
    apply(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    cmp_en = 1'b1;
    lit("rst1", 32'hFFFF_FFFF, 32'h0, 1'b0);
    apply(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    lit("rst2", 32'hFFFF_FFFF, 32'h0, 1'b0);
`ifdef OR_32_REG_FLAGS_EN
    check("rst_zero_q", {31'h0, bus.zero_q}, 32'h1);
    check("rst_ones_q", {31'h0, bus.ones_q}, 32'h0);
`endif

    // All-zero operands.
    apply(32'h0, 32'h0, 1'b1, 1'b1);
    lit("zero", 32'h0, 32'h0, 1'b1);
`ifdef OR_32_REG_FLAGS_EN
    check("zero_zero_q", {31'h0, bus.zero_q}, 32'h1);
`endif

    // Single operand pass-through, combinational check before the edge.
    bus.a = 32'h0000_FF00; bus.b = 32'h0; #1;
    check("ff00_comb", bus.data_result, 32'h0000_FF00);
    apply(32'h0000_FF00, 32'h0, 1'b1, 1'b1);
    lit("ff00", 32'h0000_FF00, 32'h0000_FF00, 1'b1);

    apply(32'h1111_1111, 32'h0, 1'b1, 1'b1);
    lit("1111", 32'h1111_1111, 32'h1111_1111, 1'b1);

    apply(32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b1);
    lit("f0f0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
`ifdef OR_32_REG_FLAGS_EN
    check("f0f0_ones_q", {31'h0, bus.ones_q}, 32'h1);
    check("f0f0_zero_q", {31'h0, bus.zero_q}, 32'h0);
`endif

    // Back-to-back ops, then an idle cycle that must hold result_q.
    apply(32'h0000_FF00, 32'h00FF_0000, 1'b1, 1'b1);
    lit("b2b1", 32'h00FF_FF00, 32'h00FF_FF00, 1'b1);
    apply(32'h8000_0001, 32'h0, 1'b1, 1'b1);
    lit("b2b2", 32'h8000_0001, 32'h8000_0001, 1'b1);
    apply(32'h0000_0010, 32'h0000_0100, 1'b0, 1'b1);
    lit("idle", 32'h0000_0110, 32'h8000_0001, 1'b0);

    // Reset coincident with a valid op: nothing captured.
    apply(32'h1234_5678, 32'h0, 1'b1, 1'b0);
    lit("rstvalid", 32'h1234_5678, 32'h0, 1'b0);

    // Randomized traffic; the negedge compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = '0;
        1: rb = ~ra;
        default: ;
      endcase
      apply(ra, rb, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) != 0));
      // Occasionally disturb operands mid-cycle; only data_result may move.
      if ($urandom_range(0, 3) == 0) begin
        bus.a = $urandom;
        bus.b = $urandom;
      end
    end

    @(negedge clock);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
